// File: rtl/max_bus_responder.sv
// rtl/max_bus_responder.sv - register responder for the FPGA max_csn/max_wen/max_oen bus
// Optional csn-low watchdog enabled by defining BUS_TIMEOUT_EN.
module max_bus_responder #(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] ID_VALUE       = 16'h5A01,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clkin_max_100,
  input  logic        sys_resetn,
  input  logic        max_csn,
  input  logic        max_wen,
  input  logic        max_oen,
  input  logic [3:0]  bus_addr,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_doe,
  input  logic        fpga_conf_done,
  input  logic        fpga_statusn,
  input  logic        cfg_busy,
  output logic [1:0]  pgm_page,
  output logic        reconfig_req
);

  typedef enum logic [2:0] {IDLE, DECODE, WRITE, WR_WAIT, READ, RD_HOLD} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] csn_sr, wen_sr, oen_sr;
  logic        csn_s, wen_s, oen_s, wen_d;
  logic [15:0] scratch;
  logic [15:0] rdata;
  logic        perr, toerr, armed, timeout;
  logic        commit, perr_set, doe_nxt;

  // Strobe synchronisers idle high so reset never looks like a transaction.
  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      csn_sr <= '1;
      wen_sr <= '1;
      oen_sr <= '1;
      wen_d  <= 1'b1;
    end else begin
      csn_sr <= {csn_sr[SYNC_STAGES-2:0], max_csn};
      wen_sr <= {wen_sr[SYNC_STAGES-2:0], max_wen};
      oen_sr <= {oen_sr[SYNC_STAGES-2:0], max_oen};
      wen_d  <= wen_s;
    end
  end

  assign csn_s = csn_sr[SYNC_STAGES-1];
  assign wen_s = wen_sr[SYNC_STAGES-1];
  assign oen_s = oen_sr[SYNC_STAGES-1];

`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt;

  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (!csn_s) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !csn_s && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // After a timeout the FSM stays parked until the initiator lets csn go.
  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      armed <= 1'b1;
      toerr <= 1'b0;
    end else begin
      if (timeout) begin
        armed <= 1'b0;
      end else if (csn_s) begin
        armed <= 1'b1;
      end
      if (timeout) begin
        toerr <= 1'b1;
      end else if (commit && bus_addr == 4'd2 && bus_din[9]) begin
        toerr <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign armed   = 1'b1;
  assign toerr   = 1'b0;
`endif

  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!csn_s && armed) state_nxt = DECODE;
      DECODE: begin
        if (!wen_s) begin
          state_nxt = WRITE;
        end else if (!oen_s) begin
          state_nxt = READ;
        end else if (csn_s) begin
          state_nxt = IDLE;
        end
      end
      WRITE:   state_nxt = WR_WAIT;
      WR_WAIT: if (wen_s || csn_s) state_nxt = IDLE;
      READ:    state_nxt = RD_HOLD;
      RD_HOLD: if (oen_s || csn_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_comb begin
    commit       = (state == WRITE) && !timeout;
    reconfig_req = commit && (bus_addr == 4'd1) && bus_din[15] && !cfg_busy;
    doe_nxt      = (state_nxt == RD_HOLD);
    perr_set     = ((state == DECODE) && !wen_s && !oen_s)
                 || (commit && (bus_addr == 4'd1)
                     && ((bus_din[15] && cfg_busy) || (bus_din[1:0] == 2'b11)))
                 || ((state == RD_HOLD) && !wen_s && wen_d);
  end

  always_comb begin
    rdata = 16'h0000;
    case (bus_addr)
      4'd0: rdata = ID_VALUE;
      4'd1: rdata = {14'b0, pgm_page};
      4'd2: rdata = {6'b0, toerr, perr, 3'b0, pgm_page, cfg_busy, fpga_statusn, fpga_conf_done};
      4'd3: rdata = scratch;
      default: rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clkin_max_100 or negedge sys_resetn) begin
    if (!sys_resetn) begin
      pgm_page <= 2'b00;
      scratch  <= 16'h0000;
      perr     <= 1'b0;
      bus_dout <= 16'h0000;
      bus_doe  <= 1'b0;
    end else begin
      bus_doe <= doe_nxt;
      if (state == READ) bus_dout <= rdata;
      if (commit && bus_addr == 4'd1 && bus_din[1:0] != 2'b11) pgm_page <= bus_din[1:0];
      if (commit && bus_addr == 4'd3) scratch <= bus_din;
      if (perr_set) begin
        perr <= 1'b1;
      end else if (commit && bus_addr == 4'd2 && bus_din[8]) begin
        perr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_bus_responder.sv
// tb/tb_max_bus_responder.sv - directed vector bench for max_bus_responder
module tb_max_bus_responder;

  logic        clk = 1'b0;
  logic        sys_resetn = 1'b0;
  logic        max_csn = 1'b1, max_wen = 1'b1, max_oen = 1'b1;
  logic [3:0]  bus_addr = 4'h0;
  logic [15:0] bus_din = 16'h0000;
  logic [15:0] bus_dout;
  logic        bus_doe;
  logic        fpga_conf_done = 1'b1, fpga_statusn = 1'b1, cfg_busy = 1'b0;
  logic [1:0]  pgm_page;
  logic        reconfig_req;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  max_bus_responder #(.SYNC_STAGES(2), .ID_VALUE(16'h5A01), .TIMEOUT_CYCLES(16)) dut (
    .clkin_max_100 (clk),
    .sys_resetn    (sys_resetn),
    .max_csn       (max_csn),
    .max_wen       (max_wen),
    .max_oen       (max_oen),
    .bus_addr      (bus_addr),
    .bus_din       (bus_din),
    .bus_dout      (bus_dout),
    .bus_doe       (bus_doe),
    .fpga_conf_done(fpga_conf_done),
    .fpga_statusn  (fpga_statusn),
    .cfg_busy      (cfg_busy),
    .pgm_page      (pgm_page),
    .reconfig_req  (reconfig_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reconfig_req) pulse_cnt = pulse_cnt + 1;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        busy;
    logic [15:0] exp;
    int          pulses;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d,
                          output int lat_on, output int lat_off);
    int n;
    @(negedge clk);
    bus_addr = a;
    repeat (3) @(negedge clk);
    max_csn = 1'b0;
    repeat (2) @(negedge clk);
    max_oen = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus_doe && n < 20);
    chk("rd_doe_rise", bus_doe, 1);
    lat_on = n;
    d = bus_dout;
    max_oen = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus_doe && n < 20);
    lat_off = n;
    max_csn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input int hold,
                           output int page_lat);
    logic [1:0] p_old;
    @(negedge clk);
    bus_addr = a;
    bus_din  = d;
    p_old    = pgm_page;
    page_lat = -1;
    repeat (3) @(negedge clk);
    max_csn = 1'b0;
    repeat (2) @(negedge clk);
    max_wen = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (page_lat < 0 && pgm_page != p_old) page_lat = i;
    end
    max_wen = 1'b1;
    repeat (2) @(negedge clk);
    max_csn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    int lon, loff, plat, p0, hi_cnt;
    logic seen;

    vecs[0]  = '{1'b0, 4'h1, 16'h0000, 1'b0, 16'h0002, 0};
    vecs[1]  = '{1'b0, 4'h2, 16'h0000, 1'b0, 16'h0013, 0};
    vecs[2]  = '{1'b1, 4'h1, 16'h8001, 1'b1, 16'h0001, 0};
    vecs[3]  = '{1'b0, 4'h2, 16'h0000, 1'b1, 16'h010F, 0};
    vecs[4]  = '{1'b1, 4'h2, 16'h0100, 1'b0, 16'h0001, 0};
    vecs[5]  = '{1'b0, 4'h2, 16'h0000, 1'b0, 16'h000B, 0};
    vecs[6]  = '{1'b1, 4'h1, 16'h0003, 1'b0, 16'h0001, 0};
    vecs[7]  = '{1'b0, 4'h2, 16'h0000, 1'b0, 16'h010B, 0};
    vecs[8]  = '{1'b1, 4'h2, 16'h0100, 1'b0, 16'h0001, 0};
    vecs[9]  = '{1'b1, 4'h3, 16'h1234, 1'b0, 16'h0001, 0};
    vecs[10] = '{1'b0, 4'h3, 16'h0000, 1'b0, 16'h1234, 0};
    vecs[11] = '{1'b1, 4'h9, 16'hFFFF, 1'b0, 16'h0001, 0};
    vecs[12] = '{1'b0, 4'h9, 16'h0000, 1'b0, 16'h0000, 0};
    vecs[13] = '{1'b0, 4'h3, 16'h0000, 1'b0, 16'h1234, 0};
    vecs[14] = '{1'b1, 4'h1, 16'h8000, 1'b0, 16'h0000, 1};
    vecs[15] = '{1'b0, 4'h2, 16'h0000, 1'b0, 16'h0003, 0};

    repeat (3) @(negedge clk);
    chk("rst_doe", bus_doe, 0);
    chk("rst_dout", bus_dout, 0);
    chk("rst_page", pgm_page, 0);
    chk("rst_reconfig", reconfig_req, 0);
    sys_resetn = 1'b1;
    repeat (2) @(negedge clk);

    bus_read(4'h0, rd, lon, loff);
    chk("id_data", rd, 16'h5A01);
    chk("rd_lat_on", lon, 4);
    chk("rd_lat_off", loff, 3);

    p0 = pulse_cnt;
    bus_write(4'h3, 16'hBEEF, 50, plat);
    chk("scratch_no_pulse", pulse_cnt - p0, 0);
    bus_read(4'h3, rd, lon, loff);
    chk("scratch_rd", rd, 16'hBEEF);

    p0 = pulse_cnt;
    bus_write(4'h1, 16'h8002, 20, plat);
    chk("ctrl_page", pgm_page, 2'b10);
    chk("ctrl_wr_lat", plat, 4);
    chk("ctrl_pulses", pulse_cnt - p0, 1);

    for (int i = 0; i < 16; i++) begin
      cfg_busy = vecs[i].busy;
      if (vecs[i].wr) begin
        p0 = pulse_cnt;
        bus_write(vecs[i].addr, vecs[i].din, 6, plat);
        chk($sformatf("vec%0d_page", i), pgm_page, vecs[i].exp[1:0]);
        chk($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].pulses);
      end else begin
        bus_read(vecs[i].addr, rd, lon, loff);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
      end
    end
    cfg_busy = 1'b0;

    // wen and oen together: write wins, no drive, PERR
    @(negedge clk);
    bus_addr = 4'h3;
    bus_din  = 16'hA5A5;
    repeat (3) @(negedge clk);
    max_csn = 1'b0;
    repeat (2) @(negedge clk);
    max_wen = 1'b0;
    max_oen = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus_doe;
    end
    max_wen = 1'b1;
    max_oen = 1'b1;
    repeat (2) @(negedge clk);
    max_csn = 1'b1;
    repeat (4) @(negedge clk);
    chk("both_no_doe", seen, 0);
    bus_read(4'h3, rd, lon, loff);
    chk("both_commit", rd, 16'hA5A5);
    bus_read(4'h2, rd, lon, loff);
    chk("both_perr", rd, 16'h0103);
    bus_write(4'h2, 16'h0100, 6, plat);
    bus_read(4'h2, rd, lon, loff);
    chk("perr_w1c", rd, 16'h0003);

    // reset asserted while driving read data
    bus_write(4'h1, 16'h0002, 6, plat);
    @(negedge clk);
    bus_addr = 4'h3;
    repeat (3) @(negedge clk);
    max_csn = 1'b0;
    repeat (2) @(negedge clk);
    max_oen = 1'b0;
    for (int i = 0; i < 20 && !bus_doe; i++) @(negedge clk);
    chk("rst_mid_doe_before", bus_doe, 1);
    #2 sys_resetn = 1'b0;
    #1;
    chk("rst_mid_doe", bus_doe, 0);
    chk("rst_mid_page", pgm_page, 0);
    chk("rst_mid_dout", bus_dout, 0);
    max_csn = 1'b1;
    max_oen = 1'b1;
    repeat (3) @(negedge clk);
    sys_resetn = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(4'h3, rd, lon, loff);
    chk("rst_scratch", rd, 16'h0000);
    bus_read(4'h2, rd, lon, loff);
    chk("rst_status", rd, 16'h0003);

    // stuck csn/oen for 40 cycles
    @(negedge clk);
    bus_addr = 4'h0;
    repeat (3) @(negedge clk);
    max_csn = 1'b0;
    max_oen = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_doe) hi_cnt++;
    end
`ifdef BUS_TIMEOUT_EN
    chk("to_doe_end", bus_doe, 0);
    chk("to_hi_cycles", hi_cnt, 14);
`else
    chk("to_doe_end", bus_doe, 1);
    chk("to_hi_cycles", hi_cnt, 36);
`endif
    max_oen = 1'b1;
    max_csn = 1'b1;
    repeat (6) @(negedge clk);
    bus_read(4'h2, rd, lon, loff);
`ifdef BUS_TIMEOUT_EN
    chk("to_status", rd, 16'h0203);
    bus_write(4'h2, 16'h0200, 6, plat);
    bus_read(4'h2, rd, lon, loff);
    chk("toerr_w1c", rd, 16'h0003);
`else
    chk("to_status", rd, 16'h0003);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
